// File: rtl/led_frame_serializer_if.sv
// led_frame_serializer_if: valid/ready byte stream feeding row bytes into the LED frame serializer.
interface led_frame_serializer_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic in_clear;
  modport master(output in_data, in_valid, in_clear, input in_ready);
  modport slave(input in_data, in_valid, in_clear, output in_ready);
endinterface

// File: rtl/led_frame_serializer.sv
// led_frame_serializer: double-buffers an 8x8 LED frame and shifts it out with a divided shift clock and latch pulse.
module led_frame_serializer #(
  parameter int SHIFT_DIV = 4,
  parameter int NBYTES = 8
) (
  input  logic clk,
  input  logic rst_n,
  led_frame_serializer_if.slave bus,
  output logic ser_data,
  output logic ser_clk,
  output logic ser_latch,
  output logic busy,
  output logic frame_done
);
  localparam int NBITS = 8 * NBYTES;
  localparam int BW = $clog2(NBITS);
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t state, state_n;
  logic [0:NBYTES-1][7:0] fill_buf;
  logic [NBITS-1:0] shift_buf;
  logic [CW-1:0] byte_cnt;
  logic fill_full;
  logic [BW-1:0] bit_cnt;
  logic [7:0] div_cnt;
  logic div_done, last_bit, last_byte, handoff, xfer;
  assign bus.in_ready = !fill_full;
  assign xfer = bus.in_valid && !fill_full;
  assign last_byte = byte_cnt == CW'(NBYTES - 1);
  assign handoff = fill_full && state == IDLE;
  assign div_done = div_cnt == 8'(SHIFT_DIV - 1);
  assign last_bit = bit_cnt == BW'(NBITS - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = handoff ? SHIFT_LO : IDLE;
      SHIFT_LO: state_n = div_done ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: state_n = !div_done ? SHIFT_HI : last_bit ? LATCH : SHIFT_LO;
      LATCH:    state_n = div_done ? IDLE : LATCH;
      default:  state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift_buf <= '0;
      ser_data <= 1'b0;
      ser_clk <= 1'b0;
      ser_latch <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      div_cnt <= (state_n != state) ? '0 : div_cnt + 8'd1;
      bit_cnt <= (state == IDLE) ? '0 : bit_cnt + BW'(state == SHIFT_HI && div_done);
      if (handoff) shift_buf <= fill_buf;
      if (state_n == SHIFT_LO && state != SHIFT_LO)
        ser_data <= handoff ? fill_buf[0][7] : shift_buf[BW'(NBITS - 2) - bit_cnt];
      ser_clk <= state_n == SHIFT_HI;
      ser_latch <= state_n == LATCH;
      busy <= state_n != IDLE;
      frame_done <= state == LATCH && state_n == IDLE;
    end
  end
  // A clear wins over a same-cycle byte; the shifter never sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_buf <= '0;
      byte_cnt <= '0;
      fill_full <= 1'b0;
    end else if (bus.in_clear) begin
      byte_cnt <= '0;
      fill_full <= 1'b0;
    end else begin
      if (handoff) fill_full <= 1'b0;
      if (xfer) begin
        fill_buf[byte_cnt] <= bus.in_data;
        byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
        if (last_byte) fill_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_frame_serializer.sv
// tb_led_frame_serializer: random and directed frames checked every cycle against a time-indexed frame model.
module tb_led_frame_serializer;
  localparam int D = 3;
  localparam int FT = 129 * D;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_data, ser_clk, ser_latch, busy, frame_done;
  led_frame_serializer_if bus();
  led_frame_serializer #(.SHIFT_DIV(D), .NBYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ser_data(ser_data), .ser_clk(ser_clk),
    .ser_latch(ser_latch), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask
  // Model: t counts cycles since handoff; every output is a function of t and the frame.
  int t = -1, m_cnt = 0;
  logic [63:0] m_frame = '0;
  logic [7:0] m_buf[8];
  bit m_full = 0, m_fd = 0, ho, full0;
  logic m_data = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = -1; m_cnt = 0; m_full = 0; m_fd = 0; m_data = 1'b0; m_frame = '0;
    end else begin
      full0 = m_full;
      ho = m_full && t < 0;
      m_fd = (t == FT - 1);
      if (ho) begin
        for (int i = 0; i < 8; i++) m_frame[63-8*i -: 8] = m_buf[i];
        t = 0;
      end else if (t >= 0) t = (t + 1 == FT) ? -1 : t + 1;
      if (bus.in_clear) begin
        m_cnt = 0; m_full = 0;
      end else begin
        if (ho) m_full = 0;
        if (bus.in_valid && !full0) begin
          m_buf[m_cnt] = bus.in_data;
          m_cnt++;
          if (m_cnt == 8) begin m_cnt = 0; m_full = 1; end
        end
      end
      if (t >= 0 && t / D < 128) m_data = m_frame[63 - t / (2 * D)];
    end
  end
  logic [63:0] chain = '0;
  int n_edges = 0, n_latch = 0, hi_run = 0, last_hi = 0, lo_run = 0, last_lo = 0;
  logic prev_clk = 1'b0, prev_data = 1'b0, prev_latch = 1'b0;
  always @(posedge ser_clk) begin
    chain = {chain[62:0], ser_data};
    n_edges++;
  end
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, !m_full);
    chk("ser_clk", ser_clk, t >= 0 && t / D < 128 && (t / D) % 2 == 1);
    chk("ser_latch", ser_latch, t >= 0 && t / D == 128);
    chk("busy", busy, t >= 0);
    chk("frame_done", frame_done, m_fd);
    chk("ser_data", ser_data, m_data);
    if (ser_clk && prev_clk) chk("data_stable_hi", ser_data, prev_data);
    if (ser_latch && !prev_latch) begin
      chk("latched_chain", chain, m_frame);
      n_latch++;
    end
    if (ser_clk) hi_run++;
    else begin if (hi_run != 0) last_hi = hi_run; hi_run = 0; end
    if (busy && !ser_clk && !ser_latch) lo_run++;
    else begin if (lo_run != 0) last_lo = lo_run; lo_run = 0; end
    prev_clk = ser_clk; prev_data = ser_data; prev_latch = ser_latch;
  end
  task automatic send(input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    bus.in_data = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < 2000) begin @(negedge clk); k++; end
    if (!bus.in_ready) timeout("send");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send(f[63-8*i -: 8]);
  endtask
  task automatic wait_done();
    int k = 0;
    do begin @(negedge clk); k++; end while (!frame_done && k < 2 * FT);
    if (!frame_done) timeout("frame_done");
  endtask
  logic [63:0] rf;
  int t0, got, k, l0;
  logic r;
  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk", ser_clk, 0);
    chk("rst_latch", ser_latch, 0);
    rst_n = 1'b1;
    // Single frame with literal expectations.
    n_edges = 0;
    send_frame(64'h8000_0000_0000_0001);
    k = 0;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    t0 = cyc;
    wait_done();
    chk("frame_time", 64'(cyc - t0), 387);
    chk("edge_count", 64'(n_edges), 64);
    chk("single_chain", chain, 64'h8000_0000_0000_0001);
    // Back-to-back frames.
    send_frame({$urandom, $urandom});
    send_frame({$urandom, $urandom});
    @(negedge clk);
    chk("b_full_ready", bus.in_ready, 0);
    wait_done();
    chk("b_pending_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("b_started_busy", busy, 1);
    chk("b_started_ready", bus.in_ready, 1);
    wait_done();
    // Continuous valid across three frames.
    l0 = n_latch; got = 0; k = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 8'($urandom);
    while (got < 24 && k < 5000) begin
      r = bus.in_ready;
      @(negedge clk);
      k++;
      if (r) begin got++; bus.in_data = 8'($urandom); end
    end
    bus.in_valid = 1'b0;
    chk("bp_bytes", 64'(got), 24);
    k = 0;
    do begin @(negedge clk); k++; end while ((busy || !bus.in_ready) && k < 4 * FT);
    if (busy || !bus.in_ready) timeout("bp_drain");
    chk("bp_frames", 64'(n_latch - l0), 3);
    // Clear with a coincident byte, then a fresh frame.
    for (int i = 0; i < 5; i++) send(8'($urandom));
    @(negedge clk);
    bus.in_clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    @(posedge clk);
    #1 bus.in_clear = 1'b0; bus.in_valid = 1'b0;
    send_frame(64'h1122_3344_5566_7788);
    wait_done();
    chk("clear_chain", chain, 64'h1122_3344_5566_7788);
    // Reset after 30 shift edges.
    n_edges = 0; l0 = n_latch;
    send_frame({$urandom, $urandom});
    k = 0;
    while (n_edges < 30 && k < 2 * FT) begin @(negedge clk); k++; end
    if (n_edges < 30) timeout("edges30");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", ser_clk, 0);
    chk("mid_rst_data", ser_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_latch", ser_latch, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("no_latch_after_rst", 64'(n_latch), 64'(l0));
    rf = {$urandom, $urandom};
    send_frame(rf);
    wait_done();
    chk("post_rst_chain", chain, rf);
    // Shift clock phase widths.
    send_frame({$urandom, $urandom});
    wait_done();
    chk("hi_phase", 64'(last_hi), 3);
    chk("lo_phase", 64'(last_lo), 3);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
